edge_counter_sequencer: RTL and testbench

//  Sequences the edge-counter controller through repeated gated count bins. On a start

---
 rtl/edge_counter_sequencer.sv | 138 +++++++++++++
 tb/tb_edge_counter_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_counter_sequencer.sv
// Drives an edge-counter controller through repeated gated count bins with one-cycle
// RESET/START/STOP/SAVE command words, and supplies a free-running 64-bit timestamp.
module edge_counter_sequencer #(
    parameter int WIN_WIDTH = 32,
    parameter int GAP_WIDTH = 32,
    parameter int BIN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIN_WIDTH-1:0] cfg_window,
    input  logic [BIN_WIDTH-1:0] cfg_bins,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    output logic [63:0]          cmd_out,
    output logic [63:0]          timestamp,
    output logic [BIN_WIDTH-1:0] bin_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 cfg_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_ARM, S_GATE, S_STOP, S_SAVE, S_GAP, S_DONE, S_ABRT
    } state_t;

    localparam logic [63:0] CMD_START = 64'd1;
    localparam logic [63:0] CMD_STOP  = 64'd2;
    localparam logic [63:0] CMD_SAVE  = 64'd4;
    localparam logic [63:0] CMD_RESET = 64'd8;

    localparam logic [WIN_WIDTH-1:0] WIN_ONE = 1;
    localparam logic [GAP_WIDTH-1:0] GAP_ONE = 1;
    localparam logic [BIN_WIDTH-1:0] BIN_ONE = 1;

    state_t               state;
    state_t               next_state;
    logic [WIN_WIDTH-1:0] win_q;
    logic [BIN_WIDTH-1:0] bins_q;
    logic [GAP_WIDTH-1:0] gap_q;
    logic [WIN_WIDTH-1:0] gate_cnt;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [63:0]          cmd_nxt;
    logic                 cfg_ok;
    logic                 last_bin;

    // start and abort are single-cycle pulses sampled on the rising clock edge; there is
    // no acknowledge, acceptance of start shows up as busy on the following cycle.
    always_comb begin
        next_state = state;
        cmd_nxt    = '0;
        cfg_ok     = (cfg_window != '0) && (cfg_bins != '0);
        last_bin   = (bin_idx == (bins_q - BIN_ONE));

        case (state)
            S_IDLE:         if (start && cfg_ok) next_state = S_CLR;
            S_CLR:          next_state = abort ? S_ABRT : S_ARM;
            S_ARM, S_GATE: begin
                if (abort)                   next_state = S_ABRT;
                else if (gate_cnt == WIN_ONE) next_state = S_STOP;
                else                          next_state = S_GATE;
            end
            S_STOP:         next_state = abort ? S_ABRT : S_SAVE;
            S_SAVE: begin
                if (abort)              next_state = S_ABRT;
                else if (last_bin)      next_state = S_DONE;
                else if (gap_q == '0)   next_state = S_CLR;
                else                    next_state = S_GAP;
            end
            S_GAP: begin
                if (abort)                  next_state = S_ABRT;
                else if (gap_cnt == GAP_ONE) next_state = S_CLR;
                else                         next_state = S_GAP;
            end
            S_DONE:         next_state = S_IDLE;
            S_ABRT:         next_state = S_IDLE;
            default:        next_state = S_IDLE;
        endcase

        // Outputs are registered, so the command is chosen from the state being entered.
        case (next_state)
            S_CLR:   cmd_nxt = CMD_RESET;
            S_ARM:   cmd_nxt = CMD_START;
            S_STOP:  cmd_nxt = CMD_STOP;
            S_SAVE:  cmd_nxt = CMD_SAVE;
            S_ABRT:  cmd_nxt = CMD_STOP;
            default: cmd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd_out   <= '0;
            timestamp <= '0;
            bin_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
            win_q     <= '0;
            bins_q    <= '0;
            gap_q     <= '0;
            gate_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= next_state;
            cmd_out   <= cmd_nxt;
            timestamp <= timestamp + 64'd1;
            busy      <= (next_state != S_IDLE);
            done      <= (next_state == S_DONE);
            aborted   <= (state == S_ABRT);
            cfg_err   <= (state == S_IDLE) && start && !cfg_ok;

            if (state == S_IDLE && next_state == S_CLR) begin
                win_q   <= cfg_window;
                bins_q  <= cfg_bins;
                gap_q   <= cfg_gap;
                bin_idx <= '0;
            end else if (state == S_SAVE && (next_state == S_CLR || next_state == S_GAP)) begin
                bin_idx <= bin_idx + BIN_ONE;
            end

            // gate_cnt counts START plus the remaining gate cycles, so STOP lands window cycles later.
            if (next_state == S_ARM)
                gate_cnt <= win_q;
            else if (state == S_ARM || state == S_GATE)
                gate_cnt <= gate_cnt - WIN_ONE;

            if (state == S_SAVE && next_state == S_GAP)
                gap_cnt <= gap_q;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt - GAP_ONE;
        end
    end

endmodule

// File: tb/tb_edge_counter_sequencer.sv
// Bench for edge_counter_sequencer: a per-run schedule model of the expected output
// stream, checked every cycle, plus literal expectations for the directed scenarios.
module tb_edge_counter_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_window = '0;
    logic [15:0] cfg_bins = '0;
    logic [31:0] cfg_gap = '0;
    logic [63:0] cmd_out;
    logic [63:0] timestamp;
    logic [15:0] bin_idx;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        cfg_err;

    always #5 clk = ~clk;

    edge_counter_sequencer #(.WIN_WIDTH(32), .GAP_WIDTH(32), .BIN_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_window(cfg_window), .cfg_bins(cfg_bins), .cfg_gap(cfg_gap),
        .cmd_out(cmd_out), .timestamp(timestamp), .bin_idx(bin_idx),
        .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err)
    );

    // One expected output cycle; kind says how an abort seen in that cycle is treated.
    typedef struct packed {
        logic [3:0]  cmd;
        logic        busy;
        logic        done;
        logic        ab;
        logic [15:0] bin;
        logic [1:0]  kind;
    } ent_t;

    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_RUN  = 2'd1;
    localparam logic [1:0] K_HOLD = 2'd2;

    ent_t        sched[$];
    ent_t        cur = '0;
    logic        exp_err = 1'b0;
    logic [63:0] ts_exp = '0;
    logic [63:0] preset_val = '0;
    int          preset_gen = 0;
    int          preset_seen = 0;

    int checks = 0;
    int errors = 0;

    logic [3:0]  trace[$];
    logic [63:0] reset_ts[$];
    logic [15:0] save_bin[$];
    int n_busy, n_done, n_ab, n_err, n_reset, n_stop, n_save, n_nz;
    logic [3:0]  t3_exp [8];

    function automatic ent_t mk(input logic [3:0] c, input logic b, input logic d,
                                input logic a, input logic [15:0] bn, input logic [1:0] k);
        ent_t e;
        e.cmd = c; e.busy = b; e.done = d; e.ab = a; e.bin = bn; e.kind = k;
        return e;
    endfunction

    // Whole run laid out up front: per bin RESET, START, window-1 quiet, STOP, SAVE, gap.
    task automatic build(input int w, input int b, input int g);
        for (int k = 0; k < b; k++) begin
            sched.push_back(mk(4'd8, 1'b1, 1'b0, 1'b0, 16'(k), K_RUN));
            sched.push_back(mk(4'd1, 1'b1, 1'b0, 1'b0, 16'(k), K_RUN));
            for (int i = 0; i < w - 1; i++)
                sched.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 16'(k), K_RUN));
            sched.push_back(mk(4'd2, 1'b1, 1'b0, 1'b0, 16'(k), K_RUN));
            sched.push_back(mk(4'd4, 1'b1, 1'b0, 1'b0, 16'(k), K_RUN));
            if (k != b - 1)
                for (int i = 0; i < g; i++)
                    sched.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 16'(k + 1), K_RUN));
        end
        sched.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 16'(b - 1), K_HOLD));
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sched.delete();
            cur         <= '0;
            exp_err     <= 1'b0;
            ts_exp      <= '0;
            preset_seen <= preset_gen;
        end else begin
            ts_exp      <= ((preset_gen != preset_seen) ? preset_val : ts_exp) + 64'd1;
            preset_seen <= preset_gen;
            exp_err     <= 1'b0;
            if (cur.kind == K_RUN && abort) begin
                sched.delete();
                sched.push_back(mk(4'd2, 1'b1, 1'b0, 1'b0, cur.bin, K_HOLD));
                sched.push_back(mk(4'd0, 1'b0, 1'b0, 1'b1, cur.bin, K_IDLE));
            end else if (!cur.busy && sched.size() == 0 && start) begin
                if (cfg_window != 0 && cfg_bins != 0)
                    build(int'(cfg_window), int'(cfg_bins), int'(cfg_gap));
                else
                    exp_err <= 1'b1;
            end
            if (sched.size() != 0) cur <= sched.pop_front();
            else                   cur <= mk(4'd0, 1'b0, 1'b0, 1'b0, cur.bin, K_IDLE);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_stats();
        trace.delete(); reset_ts.delete(); save_bin.delete();
        n_busy = 0; n_done = 0; n_ab = 0; n_err = 0;
        n_reset = 0; n_stop = 0; n_save = 0; n_nz = 0;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        chk("cmd_out",   cmd_out,       {60'd0, cur.cmd});
        chk("busy",      64'(busy),     64'(cur.busy));
        chk("done",      64'(done),     64'(cur.done));
        chk("aborted",   64'(aborted),  64'(cur.ab));
        chk("cfg_err",   64'(cfg_err),  64'(exp_err));
        chk("bin_idx",   64'(bin_idx),  64'(cur.bin));
        chk("timestamp", timestamp,     ts_exp);
        trace.push_back(cmd_out[3:0]);
        if (busy)    n_busy++;
        if (done)    n_done++;
        if (aborted) n_ab++;
        if (cfg_err) n_err++;
        if (cmd_out != 0) n_nz++;
        if (cmd_out == 64'd8) begin n_reset++; reset_ts.push_back(timestamp); end
        if (cmd_out == 64'd2) n_stop++;
        if (cmd_out == 64'd4) begin n_save++; save_bin.push_back(bin_idx); end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_run(input int w, input int b, input int g);
        cfg_window = 32'(w); cfg_bins = 16'(b); cfg_gap = 32'(g);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk("idle_within_budget", 64'(busy), 64'd0);
    endtask

    function automatic int first_idx(input logic [3:0] v);
        for (int i = 0; i < trace.size(); i++)
            if (trace[i] == v) return i;
        return -1;
    endfunction

    initial begin
        t3_exp = '{4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4};
        clear_stats();
        run(2);
        chk("rst_cmd", cmd_out, 64'd0);
        chk("rst_ts", timestamp, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        run(2);

        // window=5, one bin
        clear_stats();
        start_run(5, 1, 0);
        run(13);
        chk("t1_first_reset", 64'(trace[0]), 64'd8);
        chk("t1_stop_after_start", 64'(first_idx(4'd2) - first_idx(4'd1)), 64'd5);
        chk("t1_busy_cycles", 64'(n_busy), 64'd9);
        chk("t1_done_pulses", 64'(n_done), 64'd1);
        chk("t1_saves", 64'(n_save), 64'd1);

        // window=3, four bins, gap 2
        clear_stats();
        start_run(3, 4, 2);
        run(34);
        chk("t2_resets", 64'(n_reset), 64'd4);
        chk("t2_saves", 64'(n_save), 64'd4);
        chk("t2_done_pulses", 64'(n_done), 64'd1);
        if (reset_ts.size() == 4 && save_bin.size() == 4) begin
            for (int k = 0; k < 3; k++)
                chk("t2_period", reset_ts[k+1] - reset_ts[k], 64'd8);
            for (int k = 0; k < 4; k++)
                chk("t2_save_bin", 64'(save_bin[k]), 64'(k));
        end

        // window=1, two bins back to back
        clear_stats();
        start_run(1, 2, 0);
        run(10);
        for (int k = 0; k < 8; k++)
            chk("t3_cmd_seq", 64'(trace[k]), 64'(t3_exp[k]));
        chk("t3_done_pulses", 64'(n_done), 64'd1);

        // rejected configurations
        clear_stats();
        start_run(4, 0, 1);
        run(3);
        start_run(0, 2, 0);
        run(3);
        chk("t4_cfg_err", 64'(n_err), 64'd2);
        chk("t4_busy", 64'(n_busy), 64'd0);
        chk("t4_cmds", 64'(n_nz), 64'd0);

        // abort inside the gate of bin 1
        clear_stats();
        start_run(100, 3, 0);
        run(114);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(6);
        chk("t5_stops", 64'(n_stop), 64'd2);
        chk("t5_saves", 64'(n_save), 64'd1);
        chk("t5_aborted", 64'(n_ab), 64'd1);
        chk("t5_done", 64'(n_done), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);

        // abort and start together in IDLE: start wins
        clear_stats();
        cfg_window = 32'd2; cfg_bins = 16'd1; cfg_gap = 32'd0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_start_taken", 64'(busy), 64'd1);
        run(8);
        chk("t5_run_done", 64'(n_done), 64'd1);

        // asynchronous reset mid-gate
        start_run(50, 2, 1);
        run(20);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_cmd", cmd_out, 64'd0);
        chk("t6_ts", timestamp, 64'd0);
        chk("t6_bin", 64'(bin_idx), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_aborted", 64'(aborted), 64'd0);
        chk("t6_cfg_err", 64'(cfg_err), 64'd0);
        run(2);
        reset = 1'b1;
        run(2);

        // timestamp wrap
        force dut.timestamp = 64'hFFFF_FFFF_FFFF_FFFE;
        preset_val = 64'hFFFF_FFFF_FFFF_FFFE;
        preset_gen = preset_gen + 1;
        #1 release dut.timestamp;
        tick();
        chk("t6_ts_max", timestamp, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("t6_ts_wrap", timestamp, 64'd0);

        // random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            cfg_window = 32'($urandom_range(0, 6));
            cfg_bins   = 16'($urandom_range(0, 4));
            cfg_gap    = 32'($urandom_range(0, 3));
            start      = ($urandom_range(0, 9) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        wait_idle(200);
        run(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
